sdram_read: RTL
===============

# sdram_read

Full-page burst read engine for the SDR SDRAM controller; the read-side counterpart of `sdram_write`. After `sdram_init` asserts `init_end`, a held `rd_en` makes it:
- open the addressed row;
- issue one READ;
- capture `rd_bst_len` consecutive 16-bit words from the DQ bus, ending the burst with BURST TERMINATE;
- precharge all banks and pulse `rd_end`.

Its command/bank/address outputs are muxed onto the SDRAM pins by the controller top (or arbiter) alongside the init and write engines.

## Interface
- `T_RCD`, default 2: ACTIVE-to-READ wait, in clocks.
- `CAS_LAT`, default 3: CAS latency, in clocks; must match the mode register written by `sdram_init`.
- `T_RP`, default 2: PRECHARGE-to-idle wait, in clocks.
- `rd_clk`  in  1  single clock for all logic.
- `rd_rst_n`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  read request; held by the requester until `rd_end`.
- `rd_addr`  in  24  bits [23:22] bank, [21:9] row, [8:0] start column.
- `rd_bst_len`  in  10  words to read.
- `init_end`  in  1  SDRAM initialisation complete.
- `rd_sdram_data`  in  16  SDRAM DQ bus.
- `rd_ack`  out  1  `rd_data` holds a valid word this cycle.
- `rd_end`  out  1  one-cycle done pulse.
- `rd_sdram_cmd`  out  4  {cs_n, ras_n, cas_n, we_n}.
- `rd_sdram_bank`  out  2  bank address.
- `rd_sdram_addr`  out  13  row/column address.
- `rd_data`  out  16  captured read word.

## Operation
Commands are NOP 4'b0111, ACTIVE 4'b0011, READ 4'b0101, BURST TERMINATE 4'b0110, PRECHARGE 4'b0010.

States and encodings:
- IDLE 4'b0000
- ACT 4'b0001
- TRCD 4'b0011
- RD 4'b0010
- TCL 4'b0100
- DATA 4'b0101
- PRE 4'b0111
- TRP 4'b0110
- END 4'b1100

State behaviour (all outputs registered):
- IDLE: drives NOP, bank 2'b11, addr 13'h1FFF. Goes to ACT when `init_end && rd_en`.
- ACT, 1 cycle: drives ACTIVE, bank = `rd_addr[23:22]`, addr = `rd_addr[21:9]`. Latches `rd_addr` and N = `rd_bst_len`:
  - N = 0 is treated as 1.
  - N > 512 is clamped to 512.
- TRCD, `T_RCD` cycles: drives NOP.
- RD, 1 cycle: drives READ, latched bank, addr = {4'b0000, col[8:0]}. A10 = 0, so no auto-precharge.
- TCL, `CAS_LAT` cycles: drives NOP.
- DATA, N cycles: `rd_ack` = 1.
- PRE, 1 cycle: drives PRECHARGE, addr = 13'h0400 (A10 = 1, all banks).
- TRP, `T_RP` cycles: drives NOP.
- END, 1 cycle: `rd_end` = 1, then the block returns to IDLE.

Burst termination:
- BURST TERMINATE is issued exactly N cycles after the RD cycle, replacing NOP in that cycle.
- That cycle falls in TCL when N ≤ `CAS_LAT`, otherwise in DATA.

Other rules:
- The column wraps within the open row (SDRAM full-page behaviour). The block never crosses a row.
- `init_end` and `rd_en` are sampled only in IDLE. Changes to either outside IDLE are ignored until END.
- If `rd_en` is still high in IDLE after END, a new read starts immediately.
- A single shared wait counter is used; it clears on every state change.

## Timing
Cycle 0 is the ACT cycle.
- RD is at cycle `T_RCD`+1.
- Word k appears on DQ at cycle `T_RCD`+1+`CAS_LAT`+k.
- `rd_data` is a registered capture of `rd_sdram_data`. It holds word k at DATA cycle k, i.e. absolute cycle `T_RCD`+2+`CAS_LAT`+k.
- `rd_ack` is high for exactly N consecutive cycles.
- `rd_data` = 0 whenever `rd_ack` = 0.
- `rd_end` pulses at cycle `T_RCD`+2+`CAS_LAT`+N+1+`T_RP`.

Reset (asynchronous, any state, including mid-burst):
- State returns to IDLE.
- `rd_sdram_cmd` = NOP, `rd_sdram_bank` = 2'b11, `rd_sdram_addr` = 13'h1FFF.
- `rd_ack` = 0, `rd_end` = 0, `rd_data` = 0.
- A row left open by a mid-burst reset is recovered by `sdram_init` re-running on the same reset.

## Structure
- The shared include `sdram_param.v` holds:
  - the command encodings (NOP/ACTIVE/READ/BST/PRECHARGE);
  - the idle bank/address constants;
  - the read state encodings, which the benches' state-name decoders also use;
  - default `T_RCD`/`CAS_LAT`/`T_RP`, shared with `sdram_write`.
- Single module; no sub-module is warranted.

## Test plan
- Reset held for 10 cycles, then released: all outputs at their reset values throughout; state stays IDLE until `init_end`.
- After `init_end`, `rd_en` = 1, `rd_addr` = 24'h000000, `rd_bst_len` = 10, with memory preloaded 1..10 by `sdram_write`:
  - `rd_ack` high for 10 cycles with `rd_data` = 1..10;
  - BST at RD+10;
  - PRE, then `rd_end` one cycle;
  - command sequence ACT/READ/BST/PRE at cycles 0/3/13/17.
- `rd_bst_len` = 1: BST issued in TCL at RD+1; exactly one `rd_ack` cycle; the correct word is returned.
- `rd_bst_len` = 512 from column 9'h1F0: data wraps to column 0 within the same row; 512 ack cycles.
- `rd_rst_n` asserted at DATA cycle 4: outputs reset immediately; after re-init, a fresh read returns correct data.
- `rd_en` held high across `rd_end`: a second complete read starts from IDLE on the next cycle.

Source files
------------

// File: rtl/sdram_read_pkg.sv
// rtl/sdram_read_pkg.sv - shared SDRAM command, state and timing constants for the read engine
package sdram_read_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_BST       = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

  localparam logic [1:0]  IDLE_BANK    = 2'b11;
  localparam logic [12:0] IDLE_ADDR    = 13'h1FFF;
  localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

  localparam logic [3:0] RD_IDLE = 4'b0000;
  localparam logic [3:0] RD_ACT  = 4'b0001;
  localparam logic [3:0] RD_TRCD = 4'b0011;
  localparam logic [3:0] RD_RD   = 4'b0010;
  localparam logic [3:0] RD_TCL  = 4'b0100;
  localparam logic [3:0] RD_DATA = 4'b0101;
  localparam logic [3:0] RD_PRE  = 4'b0111;
  localparam logic [3:0] RD_TRP  = 4'b0110;
  localparam logic [3:0] RD_END  = 4'b1100;

  localparam int DEF_T_RCD   = 2;
  localparam int DEF_CAS_LAT = 3;
  localparam int DEF_T_RP    = 2;

  // A zero-length request still reads one word; a full page is 512 columns.
  function automatic logic [9:0] clamp_bst_len(input logic [9:0] len);
    if (len == 10'd0)
      return 10'd1;
    else if (len > 10'd512)
      return 10'd512;
    else
      return len;
  endfunction

endpackage

// File: rtl/sdram_read.sv
// rtl/sdram_read.sv - full-page burst read engine: ACTIVE, READ, capture N words, BST, PRECHARGE
module sdram_read
  import sdram_read_pkg::*;
#(
  parameter int T_RCD   = DEF_T_RCD,
  parameter int CAS_LAT = DEF_CAS_LAT,
  parameter int T_RP    = DEF_T_RP
) (
  input  logic        rd_clk,
  input  logic        rd_rst_n,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_bst_len,
  input  logic        init_end,
  input  logic [15:0] rd_sdram_data,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  rd_sdram_cmd,
  output logic [1:0]  rd_sdram_bank,
  output logic [12:0] rd_sdram_addr,
  output logic [15:0] rd_data
);

  logic [3:0]  state, state_d;
  logic [9:0]  cnt, cnt_d;
  logic [9:0]  bst_n;
  logic [1:0]  bank_q;
  logic [8:0]  col_q;
  logic [10:0] bst_pos;
  logic [3:0]  cmd_d;
  logic [1:0]  bank_d;
  logic [12:0] addr_d;

  always_comb begin
    state_d = state;
    case (state)
      RD_IDLE: if (init_end && rd_en)            state_d = RD_ACT;
      RD_ACT:                                    state_d = RD_TRCD;
      RD_TRCD: if (cnt == 10'(T_RCD - 1))        state_d = RD_RD;
      RD_RD:                                     state_d = RD_TCL;
      RD_TCL:  if (cnt == 10'(CAS_LAT - 1))      state_d = RD_DATA;
      RD_DATA: if (cnt == bst_n - 10'd1)         state_d = RD_PRE;
      RD_PRE:                                    state_d = RD_TRP;
      RD_TRP:  if (cnt == 10'(T_RP - 1))         state_d = RD_END;
      RD_END:                                    state_d = RD_IDLE;
      default:                                   state_d = RD_IDLE;
    endcase
  end

  assign cnt_d = (state_d != state) ? 10'd0 : cnt + 10'd1;

  // Distance of the upcoming cycle from the READ cycle; BST lands where it equals N.
  assign bst_pos = (state_d == RD_DATA) ? 11'(CAS_LAT) + 11'd1 + {1'b0, cnt_d}
                                        : {1'b0, cnt_d} + 11'd1;

  always_comb begin
    cmd_d  = CMD_NOP;
    bank_d = IDLE_BANK;
    addr_d = IDLE_ADDR;
    case (state_d)
      RD_ACT: begin
        cmd_d  = CMD_ACTIVE;
        bank_d = rd_addr[23:22];
        addr_d = rd_addr[21:9];
      end
      RD_RD: begin
        cmd_d  = CMD_READ;
        bank_d = bank_q;
        addr_d = {4'b0000, col_q};
      end
      RD_TCL, RD_DATA: begin
        if (bst_pos == {1'b0, bst_n})
          cmd_d = CMD_BST;
      end
      RD_PRE: begin
        cmd_d  = CMD_PRECHARGE;
        bank_d = bank_q;
        addr_d = PRE_ALL_ADDR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state         <= RD_IDLE;
      cnt           <= 10'd0;
      bst_n         <= 10'd1;
      bank_q        <= 2'b00;
      col_q         <= 9'd0;
      rd_sdram_cmd  <= CMD_NOP;
      rd_sdram_bank <= IDLE_BANK;
      rd_sdram_addr <= IDLE_ADDR;
      rd_ack        <= 1'b0;
      rd_end        <= 1'b0;
      rd_data       <= 16'd0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rd_sdram_cmd  <= cmd_d;
      rd_sdram_bank <= bank_d;
      rd_sdram_addr <= addr_d;
      rd_ack        <= (state_d == RD_DATA);
      rd_end        <= (state_d == RD_END);
      rd_data       <= (state_d == RD_DATA) ? rd_sdram_data : 16'd0;
      if (state == RD_IDLE && state_d == RD_ACT) begin
        bank_q <= rd_addr[23:22];
        col_q  <= rd_addr[8:0];
        bst_n  <= clamp_bst_len(rd_bst_len);
      end
    end
  end

endmodule
